// File: rtl/mips_pkg.sv
// Shared constants and types for the 16-bit MIPS datapath.
//   DATA_W   : data word width
//   ADDR_W   : data-memory address port width
//   DM_DEPTH : number of implemented data-memory words
//   word_t   : one data word
//   idx_width: bits needed to index a memory of a given depth (minimum 1)
package mips_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int DM_DEPTH = 256;

  typedef logic [DATA_W-1:0] word_t;

  // A depth of 1 still needs a 1-bit index so the vector is never zero-width.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_addr_check.sv
// Address decode for the data memory.
// Compares the full-width word address against DEPTH and produces the array
// index. Shared by the read mux and the write-enable gating so both agree on
// which addresses exist.
// Ports:
//   addr_in  in  ADDR_W  word address
//   in_range out 1       addr_in < DEPTH (full-width compare, no wrap)
//   index    out IDX_W   low bits of addr_in; only meaningful when in_range
module dm_addr_check
  import mips_pkg::*;
#(
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DEPTH  = mips_pkg::DM_DEPTH,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr_in,
  output logic              in_range,
  output logic [IDX_W-1:0]  index
);

  // One extra bit so DEPTH == 2**ADDR_W is representable and every address is in range.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  assign in_range = ({1'b0, addr_in} < DEPTH_L);
  assign index    = addr_in[IDX_W-1:0];

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory for the MEM stage.
// Reads are combinational; writes happen on the rising clock edge. An
// asynchronous active-low reset loads word[i] = i so post-reset reads are known.
// Addresses at or above DEPTH read as zero and ignore writes.
// Ports:
//   clk          in  1       clock; writes on posedge
//   rst          in  1       asynchronous reset, active low
//   addr_in      in  ADDR_W  word address
//   data_in      in  DATA_W  write data
//   WriteEnable  in  1       1 = write data_in to addr_in at next posedge
//   data_out     out DATA_W  combinational read of addr_in
module data_memory
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DEPTH  = mips_pkg::DM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              WriteEnable,
  output logic [DATA_W-1:0] data_out
);

  localparam int IDX_W = idx_width(DEPTH);

  // Flat storage; at the default DATA_W each entry is a word_t.
  logic [DATA_W-1:0] mem [DEPTH];

  logic             in_range;
  logic [IDX_W-1:0] index;

  dm_addr_check #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_addr_check (
    .addr_in  (addr_in),
    .in_range (in_range),
    .index    (index)
  );

  // Reset pattern and writes share one process so reset always wins and any
  // write issued while rst is low is lost. An X/Z WriteEnable is not true in
  // the if, so it never writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(i);
      end
    end else if (WriteEnable && in_range) begin
      mem[index] <= data_in;
    end
  end

  // Out-of-range reads return zero rather than aliasing onto low words.
  assign data_out = in_range ? mem[index] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: a per-word reference array updated
// from the write rule, compared against data_out every cycle, plus directed
// checks with hand-computed literal values.
module tb_data_memory;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;

  // clock / reset
  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic              WriteEnable;
  logic [DATA_W-1:0] data_out;

  always #5 clk = ~clk;

  data_memory #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .WriteEnable (WriteEnable),
    .data_out    (data_out)
  );

  int check_count = 0;
  int pass_count  = 0;

  // reference model: what each word should hold
  logic [DATA_W-1:0] model_mem [DEPTH];

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    int ai;
    ai = int'(a);
    if (ai < DEPTH) return model_mem[ai];
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = DATA_W'(i);
  endtask

  // reset is asynchronous: the model reloads the moment rst falls
  always @(negedge rst) model_reset();

  // a write lands only with rst high, WriteEnable exactly 1 and an existing address
  always @(posedge clk) begin
    if (rst === 1'b1 && WriteEnable === 1'b1 && int'(addr_in) < DEPTH)
      model_mem[int'(addr_in)] = data_in;
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: addr=0x%04h got=0x%04h expected=0x%04h",
                  name, addr_in, act, exp);
  endtask

  // compare process: mid-low-phase, inputs are settled and the last edge has landed
  always @(negedge clk) begin
    #2;
    check("model", data_out, model_read(addr_in));
  end

  // driver tasks
  task automatic drive(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic we);
    @(negedge clk);
    addr_in     = a;
    data_in     = d;
    WriteEnable = we;
  endtask

  task automatic read_check(input string name, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] exp);
    drive(a, 16'h0000, 1'b0);
    #1;
    check(name, data_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    addr_in     = '0;
    data_in     = '0;
    WriteEnable = 1'b0;
    model_reset();
    rst = 1'b0;
    #10;
    rst = 1'b1;

    // 1: reset pattern equals the address
    for (int i = 0; i < 16; i++) read_check("reset_pattern", ADDR_W'(i), DATA_W'(i));

    // 2: write 0x000F to address 0, others unchanged
    drive(16'd0, 16'h000F, 1'b1);
    drive(16'd0, 16'h0000, 1'b0);
    #1 check("write_addr0", data_out, 16'h000F);
    for (int i = 1; i < 16; i++) read_check("neighbours", ADDR_W'(i), DATA_W'(i));

    // 3: read-during-write at 5: old word before the edge, new word after
    drive(16'd5, 16'hBEEF, 1'b1);
    #1 check("rdw_before", data_out, 16'h0005);
    @(posedge clk);
    #1 check("rdw_after", data_out, 16'hBEEF);
    drive(16'd5, 16'h0000, 1'b0);

    // 4: WriteEnable low or X never writes
    drive(16'd7, 16'hFFFF, 1'b0);
    repeat (3) @(negedge clk);
    #1 check("we_low", data_out, 16'h0007);
    drive(16'd7, 16'hFFFF, 1'bx);
    repeat (2) @(negedge clk);
    #1 check("we_x", data_out, 16'h0007);
    drive(16'd7, 16'h0000, 1'b0);

    // 5: reset mid-operation discards writes, and WE during reset is ignored
    drive(16'd3, 16'h1234, 1'b1);
    drive(16'd3, 16'h0000, 1'b0);
    #1 check("pre_reset_write", data_out, 16'h1234);
    #2;
    rst = 1'b0;
    #1 check("reset_async", data_out, 16'h0003);
    addr_in = 16'd5;
    #1 check("reset_follows_addr", data_out, 16'h0005);
    addr_in     = 16'd3;
    data_in     = 16'h5555;
    WriteEnable = 1'b1;
    @(posedge clk);
    #1 check("we_during_reset", data_out, 16'h0003);
    @(negedge clk);
    WriteEnable = 1'b0;
    #3 rst = 1'b1;
    read_check("post_reset_addr0", 16'd0, 16'h0000);

    // 6: out-of-range reads are zero, writes are dropped, no wrap-around
    read_check("oor_read", 16'd256, 16'h0000);
    drive(16'd256, 16'hAAAA, 1'b1);
    drive(16'd256, 16'h0000, 1'b0);
    #1 check("oor_after_write", data_out, 16'h0000);
    read_check("oor_no_alias0", 16'd0, 16'h0000);
    read_check("oor_max", 16'hFFFF, 16'h0000);
    read_check("last_word", 16'd255, 16'h00FF);
    drive(16'd255, 16'hC3A5, 1'b1);
    drive(16'd255, 16'h0000, 1'b0);
    #1 check("last_word_write", data_out, 16'hC3A5);
    for (int i = 0; i < DEPTH; i += 17) read_check("sweep", ADDR_W'(i), model_read(ADDR_W'(i)));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
